// File: rtl/cvxif_copro_pkg.sv
// Shared encodings, enums and response struct for the CV-X-IF reference coprocessor.
// Purely declarative: no logic, no latency, no flow control.
// Backpressure: n/a.
package cvxif_copro_pkg;

    localparam logic [6:0] OPCODE_CUSTOM3 = 7'b1111011;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_NOP    = 3'b001;
    localparam logic [2:0] F3_MUL    = 3'b010;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;
    localparam logic [6:0] F7_MUL = 7'b0000001;

    localparam int unsigned MUL_LATENCY = 4;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_NOP,
        OP_MUL,
        OP_ILLEGAL
    } copro_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WAIT_COMMIT,
        RESP
    } state_e;

    typedef struct packed {
        logic       accept;
        logic       writeback;
        logic [1:0] register_read;
    } issue_resp_t;

    function automatic logic needs_operands(input copro_op_e op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/cvxif_copro_decoder.sv
// Custom-3 instruction decoder: instruction word -> operation plus issue response fields.
// Latency: purely combinational. MUL decoding only exists when CVXIF_COPRO_MUL_EN is defined.
// Backpressure: none; the caller qualifies the outputs with its own handshake.
module cvxif_copro_decoder
    import cvxif_copro_pkg::*;
(
    input  logic [31:0] instr_i,
    output copro_op_e   op_o,
    output issue_resp_t resp_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [14:0] unused_instr_fields;

    assign opcode              = instr_i[6:0];
    assign funct3              = instr_i[14:12];
    assign funct7              = instr_i[31:25];
    assign unused_instr_fields = {instr_i[24:15], instr_i[11:7]};

    always_comb begin
        op_o = OP_ILLEGAL;
        if (opcode == OPCODE_CUSTOM3) begin
            case (funct3)
                F3_ADDSUB: begin
                    if (funct7 == F7_ADD) begin
                        op_o = OP_ADD;
                    end else if (funct7 == F7_SUB) begin
                        op_o = OP_SUB;
                    end
                end
                F3_NOP: op_o = OP_NOP;
`ifdef CVXIF_COPRO_MUL_EN
                F3_MUL: begin
                    if (funct7 == F7_MUL) begin
                        op_o = OP_MUL;
                    end
                end
`endif
                default: op_o = OP_ILLEGAL;
            endcase
        end
    end

    always_comb begin
        resp_o = '0;
        case (op_o)
            OP_ADD, OP_SUB, OP_MUL: begin
                resp_o.accept        = 1'b1;
                resp_o.writeback     = 1'b1;
                resp_o.register_read = 2'b11;
            end
            OP_NOP:  resp_o.accept = 1'b1;
            default: resp_o = '0;
        endcase
    end

endmodule

// File: rtl/cvxif_copro_responder.sv
// CV-X-IF reference coprocessor: one instruction in flight, commit/kill tracking, result handshake.
// Latency: ADD/SUB spend ExecLatency cycles in EXEC (MUL 4, only with CVXIF_COPRO_MUL_EN), then wait for commit.
// Backpressure: issue_ready_o only in IDLE; result held stable in RESP until result_ready_i.
module cvxif_copro_responder
    import cvxif_copro_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned IdWidth     = 4,
    parameter int unsigned HartIdWidth = 1,
    parameter int unsigned ExecLatency = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   issue_valid_i,
    output logic                   issue_ready_o,
    input  logic [31:0]            issue_instr_i,
    input  logic [IdWidth-1:0]     issue_id_i,
    input  logic [HartIdWidth-1:0] issue_hartid_i,
    input  logic [2*XLEN-1:0]      register_rs_i,
    input  logic [1:0]             register_rs_valid_i,
    output logic                   issue_resp_accept_o,
    output logic                   issue_resp_writeback_o,
    output logic [1:0]             issue_resp_register_read_o,
    input  logic                   commit_valid_i,
    input  logic [IdWidth-1:0]     commit_id_i,
    input  logic                   commit_kill_i,
    output logic                   result_valid_o,
    input  logic                   result_ready_i,
    output logic [IdWidth-1:0]     result_id_o,
    output logic [HartIdWidth-1:0] result_hartid_o,
    output logic [XLEN-1:0]        result_data_o,
    output logic [4:0]             result_rd_o,
    output logic                   result_we_o
);

    localparam logic [3:0] EXEC_CNT_INIT = 4'(ExecLatency - 1);
    localparam logic [3:0] MUL_CNT_INIT  = 4'(MUL_LATENCY - 1);

    state_e                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   committed_q, committed_d;
    copro_op_e              op_q;
    logic [XLEN-1:0]        rs1_q, rs2_q, res_data_q, exec_res;
    logic [IdWidth-1:0]     id_q;
    logic [HartIdWidth-1:0] hartid_q;
    logic [4:0]             rd_q;
    logic                   res_we_q;

    copro_op_e   dec_op;
    issue_resp_t dec_resp;
    logic        needs_ops, ready_int, handshake, accept_hs;
    logic        cmt_issue, cmt_match, cmt_ok, cmt_kill, exec_done;

    cvxif_copro_decoder u_decoder (
        .instr_i (issue_instr_i),
        .op_o    (dec_op),
        .resp_o  (dec_resp)
    );

    assign needs_ops = needs_operands(dec_op);
    assign ready_int = rst_ni && (state_q == IDLE) &&
                       (!needs_ops || (register_rs_valid_i == 2'b11));
    assign handshake = issue_valid_i && ready_int;
    assign accept_hs = handshake && dec_resp.accept;

    // In IDLE the commit port is compared against the id being issued this very cycle.
    assign cmt_issue = commit_valid_i && (commit_id_i == issue_id_i);
    assign cmt_match = commit_valid_i && (commit_id_i == id_q);
    assign cmt_ok    = cmt_match && !commit_kill_i;
    assign cmt_kill  = cmt_match && commit_kill_i;
    assign exec_done = (cnt_q == 4'd0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            committed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        committed_d = committed_q;
        case (state_q)
            IDLE: begin
                committed_d = 1'b0;
                if (accept_hs && !(cmt_issue && commit_kill_i)) begin
                    committed_d = cmt_issue;
                    if (needs_ops) begin
                        state_d = EXEC;
                        cnt_d   = (dec_op == OP_MUL) ? MUL_CNT_INIT : EXEC_CNT_INIT;
                    end else begin
                        state_d = WAIT_COMMIT;
                    end
                end
            end
            EXEC: begin
                committed_d = committed_q || cmt_ok;
                if (cmt_kill) begin
                    state_d = IDLE;
                end else if (exec_done) begin
                    state_d = committed_d ? RESP : WAIT_COMMIT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WAIT_COMMIT: begin
                if (cmt_kill) begin
                    state_d = IDLE;
                end else if (committed_q || cmt_ok) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) begin
            committed_d = 1'b0;
        end
    end

    always_comb begin
        exec_res = '0;
        case (op_q)
            OP_ADD:  exec_res = rs1_q + rs2_q;
            OP_SUB:  exec_res = rs1_q - rs2_q;
`ifdef CVXIF_COPRO_MUL_EN
            OP_MUL:  exec_res = rs1_q * rs2_q;
`endif
            default: exec_res = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            op_q       <= OP_ILLEGAL;
            rs1_q      <= '0;
            rs2_q      <= '0;
            id_q       <= '0;
            hartid_q   <= '0;
            rd_q       <= 5'd0;
            res_we_q   <= 1'b0;
            res_data_q <= '0;
        end else if ((state_q == IDLE) && accept_hs) begin
            op_q       <= dec_op;
            rs1_q      <= register_rs_i[XLEN-1:0];
            rs2_q      <= register_rs_i[2*XLEN-1:XLEN];
            id_q       <= issue_id_i;
            hartid_q   <= issue_hartid_i;
            rd_q       <= issue_instr_i[11:7];
            res_we_q   <= dec_resp.writeback;
            res_data_q <= '0;
        end else if ((state_q == EXEC) && exec_done && !cmt_kill) begin
            res_data_q <= exec_res;
        end
    end

    always_comb begin
        issue_ready_o              = ready_int;
        issue_resp_accept_o        = handshake && dec_resp.accept;
        issue_resp_writeback_o     = handshake && dec_resp.writeback;
        issue_resp_register_read_o = handshake ? dec_resp.register_read : 2'b00;
        result_valid_o             = (state_q == RESP);
        result_id_o                = id_q;
        result_hartid_o            = hartid_q;
        result_data_o              = res_data_q;
        result_rd_o                = rd_q;
        result_we_o                = res_we_q;
    end

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Scoreboard bench for cvxif_copro_responder: directed issues push expected results, a monitor pops on result handshakes.
module tb_cvxif_copro_responder;

    typedef struct packed {
        logic [3:0]  id;
        logic        hart;
        logic [63:0] data;
        logic [4:0]  rd;
        logic        we;
    } res_t;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         issue_valid_i = 1'b0;
    logic         issue_ready_o;
    logic [31:0]  issue_instr_i = '0;
    logic [3:0]   issue_id_i = '0;
    logic         issue_hartid_i = 1'b0;
    logic [127:0] register_rs_i = '0;
    logic [1:0]   register_rs_valid_i = 2'b11;
    logic         issue_resp_accept_o;
    logic         issue_resp_writeback_o;
    logic [1:0]   issue_resp_register_read_o;
    logic         commit_valid_i = 1'b0;
    logic [3:0]   commit_id_i = '0;
    logic         commit_kill_i = 1'b0;
    logic         result_valid_o;
    logic         result_ready_i = 1'b1;
    logic [3:0]   result_id_o;
    logic         result_hartid_o;
    logic [63:0]  result_data_o;
    logic [4:0]   result_rd_o;
    logic         result_we_o;

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t cur, held, exp_r;
    logic hold_pending = 1'b0;

    localparam logic [6:0] CUST = 7'b1111011;

    cvxif_copro_responder dut (
        .clk_i                      (clk_i),
        .rst_ni                     (rst_ni),
        .issue_valid_i              (issue_valid_i),
        .issue_ready_o              (issue_ready_o),
        .issue_instr_i              (issue_instr_i),
        .issue_id_i                 (issue_id_i),
        .issue_hartid_i             (issue_hartid_i),
        .register_rs_i              (register_rs_i),
        .register_rs_valid_i        (register_rs_valid_i),
        .issue_resp_accept_o        (issue_resp_accept_o),
        .issue_resp_writeback_o     (issue_resp_writeback_o),
        .issue_resp_register_read_o (issue_resp_register_read_o),
        .commit_valid_i             (commit_valid_i),
        .commit_id_i                (commit_id_i),
        .commit_kill_i              (commit_kill_i),
        .result_valid_o             (result_valid_o),
        .result_ready_i             (result_ready_i),
        .result_id_o                (result_id_o),
        .result_hartid_o            (result_hartid_o),
        .result_data_o              (result_data_o),
        .result_rd_o                (result_rd_o),
        .result_we_o                (result_we_o)
    );

    always #5 clk_i = ~clk_i;

    assign cur = {result_id_o, result_hartid_o, result_data_o, result_rd_o, result_we_o};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Result monitor: stability while stalled, and scoreboard pop on every result handshake.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (hold_pending) begin
                checks++;
                if (!result_valid_o || cur !== held) begin
                    errors++;
                    $display("FAIL hold_stable: valid %0b got %h expected %h", result_valid_o, cur, held);
                end
            end
            if (result_valid_o && result_ready_i) begin
                hold_pending = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %h expected none", cur);
                end else begin
                    exp_r = exp_q.pop_front();
                    if (cur !== exp_r) begin
                        errors++;
                        $display("FAIL result: got %h expected %h", cur, exp_r);
                    end
                end
            end else if (result_valid_o) begin
                hold_pending = 1'b1;
                held = cur;
            end else begin
                hold_pending = 1'b0;
            end
        end else begin
            hold_pending = 1'b0;
        end
    end

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] opc);
        return {f7, 5'd0, 5'd0, f3, rd, opc};
    endfunction

    task automatic issue(input logic [31:0] instr, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] id, input logic hart, input logic cmt_same,
                         input logic exp_acc, input logic exp_wb, input logic [1:0] exp_rr);
        int n;
        @(negedge clk_i);
        issue_valid_i = 1'b1;
        issue_instr_i = instr;
        register_rs_i = {b, a};
        issue_id_i = id;
        issue_hartid_i = hart;
        register_rs_valid_i = 2'b11;
        if (cmt_same) begin
            commit_valid_i = 1'b1;
            commit_id_i = id;
            commit_kill_i = 1'b0;
        end
        #1;
        n = 0;
        while (!issue_ready_o && n < 50) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        check("issue_ready", issue_ready_o, 1);
        check("resp_accept", issue_resp_accept_o, exp_acc);
        check("resp_writeback", issue_resp_writeback_o, exp_wb);
        check("resp_register_read", issue_resp_register_read_o, exp_rr);
        @(posedge clk_i);
        #1;
        issue_valid_i = 1'b0;
        commit_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        @(negedge clk_i);
        commit_valid_i = 1'b1;
        commit_id_i = id;
        commit_kill_i = kill;
        @(posedge clk_i);
        #1;
        commit_valid_i = 1'b0;
        commit_kill_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(issue_ready_o && !result_valid_o) && n < 100);
        check("wait_idle", issue_ready_o && !result_valid_o, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_issue_ready", issue_ready_o, 0);
        check("rst_result_valid", result_valid_o, 0);
        check("rst_result_data", result_data_o, 0);
        check("rst_resp_accept", issue_resp_accept_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("idle_ready", issue_ready_o, 1);

        // ADD 5+7, commit during EXEC, result in cycle 3 after the handshake
        exp_q.push_back('{id: 4'd3, hart: 1'b0, data: 64'd12, rd: 5'd5, we: 1'b1});
        issue(mk(7'b0000000, 3'b000, 5'd5, CUST), 64'd5, 64'd7, 4'd3, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11);
        do_commit(4'd3, 1'b0);
        @(negedge clk_i);
        check("add_valid_cycle2", result_valid_o, 0);
        @(negedge clk_i);
        check("add_valid_cycle3", result_valid_o, 1);
        wait_idle();

        // SUB wrap, stray kill for another id ignored, commit in WAIT_COMMIT
        exp_q.push_back('{id: 4'd4, hart: 1'b0, data: 64'hFFFF_FFFF_FFFF_FFFF, rd: 5'd10, we: 1'b1});
        issue(mk(7'b0100000, 3'b000, 5'd10, CUST), 64'd0, 64'd1, 4'd4, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11);
        repeat (4) @(negedge clk_i);
        do_commit(4'd9, 1'b1);
        do_commit(4'd4, 1'b0);
        wait_idle();

        // Kill in WAIT_COMMIT: no result, ready the next cycle
        issue(mk(7'b0000000, 3'b000, 5'd1, CUST), 64'd1, 64'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11);
        repeat (4) @(negedge clk_i);
        do_commit(4'd2, 1'b1);
        @(negedge clk_i);
        check("kill_ready_next", issue_ready_o, 1);
        check("kill_no_valid", result_valid_o, 0);
        repeat (4) @(negedge clk_i);

        // Backpressure with commit on the issue cycle; kill in RESP ignored
        result_ready_i = 1'b0;
        exp_q.push_back('{id: 4'd6, hart: 1'b0, data: 64'd123, rd: 5'd31, we: 1'b1});
        issue(mk(7'b0000000, 3'b000, 5'd31, CUST), 64'd100, 64'd23, 4'd6, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!result_valid_o && n < 20);
        check("bp_valid_seen", result_valid_o, 1);
        @(posedge clk_i);
        #1;
        commit_valid_i = 1'b1;
        commit_id_i = 4'd6;
        commit_kill_i = 1'b1;
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        commit_valid_i = 1'b0;
        commit_kill_i = 1'b0;
        repeat (3) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        result_ready_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        check("bp_valid_dropped", result_valid_o, 0);
        check("bp_idle_ready", issue_ready_o, 1);

        // NOP on hart 1: result with we=0 and data=0
        exp_q.push_back('{id: 4'd7, hart: 1'b1, data: 64'd0, rd: 5'd3, we: 1'b0});
        issue(mk(7'h15, 3'b001, 5'd3, CUST), 64'd55, 64'd66, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
        repeat (2) @(negedge clk_i);
        do_commit(4'd7, 1'b0);
        wait_idle();

        // Illegal opcode: rejected, stays IDLE
        issue(mk(7'b0000000, 3'b000, 5'd5, 7'b0110011), 64'd1, 64'd2, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        @(negedge clk_i);
        check("illegal_idle", issue_ready_o, 1);
        check("illegal_no_valid", result_valid_o, 0);

        // ADD without operand valid is not ready
        @(negedge clk_i);
        issue_instr_i = mk(7'b0000000, 3'b000, 5'd5, CUST);
        register_rs_valid_i = 2'b01;
        issue_valid_i = 1'b1;
        #1;
        check("rs_invalid_not_ready", issue_ready_o, 0);
        @(negedge clk_i);
        issue_valid_i = 1'b0;
        register_rs_valid_i = 2'b11;

`ifdef CVXIF_COPRO_MUL_EN
        exp_q.push_back('{id: 4'd9, hart: 1'b0, data: 64'd42, rd: 5'd7, we: 1'b1});
        issue(mk(7'b0000001, 3'b010, 5'd7, CUST), 64'd6, 64'd7, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11);
        do_commit(4'd9, 1'b0);
        repeat (2) @(negedge clk_i);
        @(negedge clk_i);
        check("mul_valid_cycle4", result_valid_o, 0);
        @(negedge clk_i);
        check("mul_valid_cycle5", result_valid_o, 1);
        wait_idle();
`else
        issue(mk(7'b0000001, 3'b010, 5'd7, CUST), 64'd6, 64'd7, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        @(negedge clk_i);
        check("mul_off_idle", issue_ready_o, 1);
`endif

        // Reset mid-operation drops the instruction
        issue(mk(7'b0000000, 3'b000, 5'd2, CUST), 64'd9, 64'd9, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("midrst_ready", issue_ready_o, 1);
        check("midrst_no_valid", result_valid_o, 0);
        do_commit(4'd1, 1'b0);

        repeat (10) @(negedge clk_i);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
